fetch_unit: RTL

//  Instruction fetch stage; sits directly upstream of the decode stage.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

    localparam int unsigned     XLEN        = 32;
    localparam int unsigned     INSTR_WIDTH = 32;
    localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the fetch queue and the request PC tag queue.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests, in-order fetch queue, redirect flush.
// Optional FETCH_PERF_EN adds stall and flush performance counters.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = riscv_pkg::INSTR_WIDTH,
    parameter logic [31:0] RESET_PC    = riscv_pkg::RESET_PC,
    parameter int unsigned FQ_DEPTH    = 4,
    parameter int unsigned MAX_OUTST   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_en,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req,
    input  logic                   imem_gnt,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [XLEN-1:0]        instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [15:0]            perf_flush_cnt
`endif
);
    localparam int unsigned QCW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTST + 1);

    fetch_state_t                  state_q;
    logic [XLEN-1:0]               pc_q, pc_d;
    logic [OW-1:0]                 drop_q, drop_d;
    logic [OW-1:0]                 outst;
    logic [OW-1:0]                 tag_count;
    logic [QCW-1:0]                fq_count;
    logic [XLEN-1:0]               tag_pc;
    logic [INSTR_WIDTH+XLEN-1:0]   fq_head;
    logic                          grant, rsp_keep, fq_pop;

    // Live requests sit in the tag FIFO; stale ones are tracked only by drop_q.
    assign outst = tag_count + drop_q;

    assign imem_req = (state_q == S_RUN) && !redirect
                    && ((32'(fq_count) + 32'(outst)) < FQ_DEPTH)
                    && (32'(outst) < MAX_OUTST);
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    assign rsp_keep  = imem_rvalid && (drop_q == '0) && !redirect;

    assign instr_valid = (fq_count != '0);
    assign fq_pop      = instr_valid && instr_ready;
    assign instr       = fq_head[INSTR_WIDTH+XLEN-1:XLEN];
    assign instr_pc    = fq_head[XLEN-1:0];

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (grant) pc_d = pc_q + 32'd4;
        if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - OW'(1);
        if (redirect) begin
            pc_d   = word_align(redirect_pc);
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d = outst - OW'(imem_rvalid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE:  if (fetch_en)  state_q <= S_RUN;
                S_RUN:   if (!fetch_en) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (INSTR_WIDTH + XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (rsp_keep),
        .pop_i   (fq_pop),
        .data_i  ({imem_rdata, tag_pc}),
        .data_o  (fq_head),
        .count_o (fq_count)
    );

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (grant),
        .pop_i   (rsp_keep),
        .data_i  (pc_q),
        .data_o  (tag_pc),
        .count_o (tag_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q == S_RUN) && !fq_pop && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (redirect) flush_q <= flush_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`endif

endmodule
